// File: rtl/control_sequencer.sv
// Microcoded control sequencer for the 8-bit bus machine: T-state counter, halt flag and control-word decode.
// Optional SEQ_EARLY_END_EN: return to T0 right after the last active execute step of each opcode.
module control_sequencer #(
   parameter int c_steps      = 5,
   parameter int c_step_width = 3
) (
   input  logic                    i_clock,
   input  logic                    i_reset_n,
   input  logic                    i_enable,
   input  logic [3:0]              i_opcode,
   input  logic                    i_carry,
   input  logic                    i_zero,
   output logic [15:0]             o_control,
   output logic [c_step_width-1:0] o_step,
   output logic                    o_halted
);

   typedef enum logic [3:0] {
      op_nop = 4'h0,
      op_lda = 4'h1,
      op_add = 4'h2,
      op_sub = 4'h3,
      op_sta = 4'h4,
      op_ldi = 4'h5,
      op_jmp = 4'h6,
      op_jc  = 4'h7,
      op_jz  = 4'h8,
      op_out = 4'hE,
      op_hlt = 4'hF
   } opcode_t;

   localparam logic [15:0] c_pco   = 16'h0001;
   localparam logic [15:0] c_pcinc = 16'h0002;
   localparam logic [15:0] c_pci   = 16'h0004;
   localparam logic [15:0] c_mari  = 16'h0008;
   localparam logic [15:0] c_rami  = 16'h0010;
   localparam logic [15:0] c_ramo  = 16'h0020;
   localparam logic [15:0] c_iri   = 16'h0040;
   localparam logic [15:0] c_iro   = 16'h0080;
   localparam logic [15:0] c_ai    = 16'h0100;
   localparam logic [15:0] c_ao    = 16'h0200;
   localparam logic [15:0] c_bi    = 16'h0400;
   localparam logic [15:0] c_aluo  = 16'h0800;
   localparam logic [15:0] c_su    = 16'h1000;
   localparam logic [15:0] c_fli   = 16'h2000;
   localparam logic [15:0] c_outi  = 16'h4000;
   localparam logic [15:0] c_hlt   = 16'h8000;

   localparam logic [c_step_width-1:0] c_t0   = c_step_width'(0);
   localparam logic [c_step_width-1:0] c_t1   = c_step_width'(1);
   localparam logic [c_step_width-1:0] c_t2   = c_step_width'(2);
   localparam logic [c_step_width-1:0] c_t3   = c_step_width'(3);
   localparam logic [c_step_width-1:0] c_t4   = c_step_width'(4);
   localparam logic [c_step_width-1:0] c_last = c_step_width'(c_steps - 1);

   opcode_t                 opcode;
   logic [c_step_width-1:0] step;
   logic [c_step_width-1:0] step_next;
   logic                    halted;
   logic                    halted_next;
   logic [15:0]             exec_word;

   assign opcode = opcode_t'(i_opcode);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         step   <= '0;
         halted <= 1'b0;
      end else begin
         step   <= step_next;
         halted <= halted_next;
      end
   end

`ifdef SEQ_EARLY_END_EN
   logic [c_step_width-1:0] last_step;

   always_comb begin
      case (opcode)
         op_lda, op_sta: last_step = c_t3;
         op_add, op_sub: last_step = c_t4;
         default:        last_step = c_t2;
      endcase
   end
`endif

   always_comb begin
      step_next   = step;
      halted_next = halted;
      if (i_enable && !halted) begin
         if (step == c_t2 && opcode == op_hlt) begin
            halted_next = 1'b1;
`ifdef SEQ_EARLY_END_EN
         end else if (step == c_last || (step >= c_t2 && step == last_step)) begin
`else
         end else if (step == c_last) begin
`endif
            step_next = '0;
         end else begin
            step_next = step + c_step_width'(1);
         end
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      exec_word = 16'h0000;
      case (opcode)
         op_lda: begin
            if (step == c_t2) exec_word = c_iro | c_mari;
            if (step == c_t3) exec_word = c_ramo | c_ai;
         end
         op_add, op_sub: begin
            if (step == c_t2) exec_word = c_iro | c_mari;
            if (step == c_t3) exec_word = c_ramo | c_bi;
            if (step == c_t4) exec_word = c_aluo | c_ai | c_fli | ((opcode == op_sub) ? c_su : 16'h0000);
         end
         op_sta: begin
            if (step == c_t2) exec_word = c_iro | c_mari;
            if (step == c_t3) exec_word = c_ao | c_rami;
         end
         op_ldi: if (step == c_t2) exec_word = c_iro | c_ai;
         op_jmp: if (step == c_t2) exec_word = c_iro | c_pci;
         op_jc:  if (step == c_t2 && i_carry) exec_word = c_iro | c_pci;
         op_jz:  if (step == c_t2 && i_zero) exec_word = c_iro | c_pci;
         op_out: if (step == c_t2) exec_word = c_ao | c_outi;
         op_hlt: if (step == c_t2) exec_word = c_hlt;
         default: exec_word = 16'h0000;
      endcase
   end

   always_comb begin
      o_control = 16'h0000;
      if (halted) begin
         o_control = c_hlt;
      end else if (i_enable) begin
         case (step)
            c_t0:    o_control = c_pco | c_mari;
            c_t1:    o_control = c_ramo | c_iri | c_pcinc;
            default: o_control = exec_word;
         endcase
      end
   end

   assign o_step   = step;
   assign o_halted = halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed test-plan steps followed by random stimulus
// compared against a table-driven reference model; honours SEQ_EARLY_END_EN like the design.
module tb_control_sequencer;

   logic        i_clock = 1'b0;
   logic        i_reset_n;
   logic        i_enable;
   logic [3:0]  i_opcode;
   logic        i_carry;
   logic        i_zero;
   logic [15:0] o_control;
   logic [2:0]  o_step;
   logic        o_halted;

   int n_cmp  = 0;
   int n_fail = 0;

   int          m_step   = 0;
   bit          m_halted = 1'b0;
   logic [15:0] exec_tbl [16][3];

   control_sequencer dut (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_enable  (i_enable),
      .i_opcode  (i_opcode),
      .i_carry   (i_carry),
      .i_zero    (i_zero),
      .o_control (o_control),
      .o_step    (o_step),
      .o_halted  (o_halted)
   );

   always #5 i_clock = ~i_clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Control word for one T-state, read from the microcode table.
   function automatic logic [15:0] model_word(input int op, input int st, input bit c, input bit z);
      if (st == 0) return 16'h0009;
      if (st == 1) return 16'h0062;
      if (st > 4) return 16'h0000;
      if (op == 7 && !c) return 16'h0000;
      if (op == 8 && !z) return 16'h0000;
      return exec_tbl[op][st-2];
   endfunction

   function automatic int model_last(input int op, input bit c, input bit z);
      int last;
      last = 4;
`ifdef SEQ_EARLY_END_EN
      last = 2;
      for (int k = 2; k <= 4; k++)
         if (model_word(op, k, c, z) != 16'h0000) last = k;
`endif
      return last;
   endfunction

   function automatic logic [15:0] model_control();
      if (m_halted) return 16'h8000;
      if (!i_enable) return 16'h0000;
      return model_word(int'(i_opcode), m_step, i_carry, i_zero);
   endfunction

   task automatic model_edge();
      if (!i_reset_n) begin
         m_step   = 0;
         m_halted = 1'b0;
      end else if (i_enable && !m_halted) begin
         if (m_step == 2 && i_opcode == 4'hF) m_halted = 1'b1;
         else if (m_step == model_last(int'(i_opcode), i_carry, i_zero)) m_step = 0;
         else m_step = m_step + 1;
      end
   endtask

   task automatic set_in(input logic rst_n, input logic en, input logic [3:0] op, input logic c, input logic z);
      i_reset_n = rst_n;
      i_enable  = en;
      i_opcode  = op;
      i_carry   = c;
      i_zero    = z;
      #1;
   endtask

   // Compare the settled outputs with the model, then advance one clock.
   task automatic tick();
      chk("step", 32'(o_step), 32'(m_step));
      chk("halted", 32'(o_halted), 32'(m_halted));
      chk("control", 32'(o_control), 32'(model_control()));
      chk("one_driver", 32'($countones(o_control & 16'h0AA1) <= 1), 32'd1);
      @(posedge i_clock);
      model_edge();
      #1;
   endtask

   task automatic finish_instr();
      for (int i = 0; i < 6 && m_step != 0; i++) tick();
      chk("back_to_t0", 32'(o_step), 32'd0);
   endtask

   initial begin
      logic [15:0] lda_seq[$];

      for (int o = 0; o < 16; o++)
         for (int s = 0; s < 3; s++) exec_tbl[o][s] = 16'h0000;
      exec_tbl[1]  = '{16'h0088, 16'h0120, 16'h0000};
      exec_tbl[2]  = '{16'h0088, 16'h0420, 16'h2900};
      exec_tbl[3]  = '{16'h0088, 16'h0420, 16'h3900};
      exec_tbl[4]  = '{16'h0088, 16'h0210, 16'h0000};
      exec_tbl[5]  = '{16'h0180, 16'h0000, 16'h0000};
      exec_tbl[6]  = '{16'h0084, 16'h0000, 16'h0000};
      exec_tbl[7]  = '{16'h0084, 16'h0000, 16'h0000};
      exec_tbl[8]  = '{16'h0084, 16'h0000, 16'h0000};
      exec_tbl[14] = '{16'h4200, 16'h0000, 16'h0000};
      exec_tbl[15] = '{16'h8000, 16'h0000, 16'h0000};

      // Initial reset: DUT state is unknown until the first reset edge.
      set_in(1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
      @(posedge i_clock);
      model_edge();
      #1;
      tick();
      set_in(1'b1, 1'b1, 4'h1, 1'b0, 1'b0);
      chk("reset_step", 32'(o_step), 32'd0);
      chk("reset_halted", 32'(o_halted), 32'd0);
      chk("reset_control", 32'(o_control), 32'h0009);

      // LDA sequence.
`ifdef SEQ_EARLY_END_EN
      lda_seq = '{16'h0009, 16'h0062, 16'h0088, 16'h0120};
`else
      lda_seq = '{16'h0009, 16'h0062, 16'h0088, 16'h0120, 16'h0000};
`endif
      foreach (lda_seq[i]) begin
         chk("lda_word", 32'(o_control), 32'(lda_seq[i]));
         tick();
      end
      chk("lda_wrap", 32'(o_control), 32'h0009);

      // Reset mid-instruction at T3.
      tick(); tick(); tick();
      chk("mid_step3", 32'(o_step), 32'd3);
      set_in(1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 1'b1, 4'h1, 1'b0, 1'b0);
      chk("mid_reset_step", 32'(o_step), 32'd0);
      chk("mid_reset_halted", 32'(o_halted), 32'd0);
      chk("mid_reset_control", 32'(o_control), 32'h0009);

      // SUB execute words.
      set_in(1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
      tick(); tick(); tick();
      chk("sub_t3", 32'(o_control), 32'h0420);
      tick();
      chk("sub_t4", 32'(o_control), 32'h3900);
      finish_instr();

      // JC taken, then not taken.
      set_in(1'b1, 1'b1, 4'h7, 1'b1, 1'b0);
      tick(); tick();
      chk("jc_taken_t2", 32'(o_control), 32'h0084);
      finish_instr();
      set_in(1'b1, 1'b1, 4'h7, 1'b0, 1'b1);
      tick(); tick();
      chk("jc_not_taken_t2", 32'(o_control), 32'h0000);
      tick();
`ifdef SEQ_EARLY_END_EN
      chk("jc_not_taken_next", 32'(o_step), 32'd0);
`else
      chk("jc_not_taken_next", 32'(o_step), 32'd3);
`endif
      finish_instr();

      // Freeze at T1.
      set_in(1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 1'b0, 4'h2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         chk("freeze_control", 32'(o_control), 32'h0000);
         chk("freeze_step", 32'(o_step), 32'd1);
         tick();
      end
      set_in(1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
      chk("unfreeze_control", 32'(o_control), 32'h0062);
      tick();
      chk("unfreeze_step", 32'(o_step), 32'd2);
      finish_instr();

      // HLT, then hold with enable toggling, then reset out of halt.
      set_in(1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
      tick(); tick();
      chk("hlt_t2", 32'(o_control), 32'h8000);
      tick();
      chk("hlt_halted", 32'(o_halted), 32'd1);
      for (int i = 0; i < 10; i++) begin
         set_in(1'b1, 1'(i % 2), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
         chk("hlt_hold_step", 32'(o_step), 32'd2);
         chk("hlt_hold_control", 32'(o_control), 32'h8000);
         tick();
      end
      set_in(1'b0, 1'b0, 4'hF, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
      chk("hlt_reset_step", 32'(o_step), 32'd0);
      chk("hlt_reset_halted", 32'(o_halted), 32'd0);

      // Random traffic against the model.
      for (int i = 0; i < 800; i++) begin
         int r;
         r = $urandom_range(0, 99);
         set_in(!(m_halted ? (r < 25) : (r < 2)), 1'($urandom_range(0, 9) != 0),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
